// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back data cache with an uncached IO window. DCACHE_STATS_EN adds hit/miss counters.
// Latency: hit response 2 cycles after accept; miss response 2 cycles after refill memDone.
// Backpressure: single outstanding request, reqReady only in IDLE; memReq/ioReq held until their done pulse.
module dcache_assoc #(
  parameter int BLOCK_WIDTH = 4,
  parameter int SET_WIDTH   = 6,
  parameter int WAY_WIDTH   = 1
) (
  input  logic                          clkIn,
  input  logic                          resetNIn,
  input  logic                          clearIn,
  input  logic                          reqValid,
  output logic                          reqReady,
  input  logic                          readWriteIn,
  input  logic [1:0]                    accessType,
  input  logic [31:0]                   dataAddrIn,
  input  logic [31:0]                   dataIn,
  output logic                          dataOutValid,
  output logic [31:0]                   dataOut,
  output logic                          dataWriteSuc,
  output logic                          misalignErr,
  output logic                          memReq,
  output logic                          memWrite,
  output logic [31-BLOCK_WIDTH:0]       memAddr,
  output logic [(2**BLOCK_WIDTH)*8-1:0] memWriteData,
  input  logic                          memDone,
  input  logic [(2**BLOCK_WIDTH)*8-1:0] memReadData,
  output logic                          ioReq,
  output logic                          ioWrite,
  output logic [31:0]                   ioAddr,
  output logic [31:0]                   ioData,
  output logic [1:0]                    ioType,
  input  logic                          ioDone,
  input  logic [31:0]                   ioReadData,
  output logic [31:0]                   hitCount,
  output logic [31:0]                   missCount
);
  localparam int BLOCK_SIZE = 2**BLOCK_WIDTH;
  localparam int LINE_W     = BLOCK_SIZE*8;
  localparam int SETS       = 2**SET_WIDTH;
  localparam int WAYS       = 2**WAY_WIDTH;
  localparam int TAG_W      = 32-SET_WIDTH-BLOCK_WIDTH;
  localparam int WI         = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_RESP, S_IO} state_t;
  state_t r_state, w_next;

  logic              r_rw;
  logic [1:0]        r_type;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_abort;
  logic              r_misalign;
  logic [31:0]       r_dout;
  logic [WI-1:0]     r_victim;

  logic [WAYS-1:0]   r_valid [SETS];
  logic [WAYS-1:0]   r_dirty [SETS];
  logic [WI-1:0]     r_ptr   [SETS];
  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [LINE_W-1:0] r_line  [WAYS][SETS];

  logic [SET_WIDTH-1:0]   w_set;
  logic [TAG_W-1:0]       w_tag;
  logic [BLOCK_WIDTH-1:0] w_off;
  logic                   w_accept, w_in_misalign, w_in_legal, w_in_io, w_in_drop;
  logic                   w_hit, w_kill, w_victim_dirty;
  logic [WI-1:0]          w_hit_way, w_victim, w_ptr_next;
  logic [LINE_W-1:0]      w_hit_line, w_wdata_sh, w_merged, w_vline;
  logic [TAG_W-1:0]       w_vtag;
  logic [BLOCK_SIZE-1:0]  w_bmask_base, w_bmask;
  logic [31:0]            w_word, w_load;

  assign w_set = r_addr[SET_WIDTH+BLOCK_WIDTH-1:BLOCK_WIDTH];
  assign w_tag = r_addr[31:SET_WIDTH+BLOCK_WIDTH];
  assign w_off = r_addr[BLOCK_WIDTH-1:0];

  assign w_accept      = reqValid && (r_state == S_IDLE);
  assign w_in_legal    = (accessType != 2'b00);
  assign w_in_misalign = (accessType == 2'b10 && dataAddrIn[0]) ||
                         (accessType == 2'b11 && dataAddrIn[1:0] != 2'b00);
  assign w_in_io       = (dataAddrIn[17:16] == 2'b11);
  assign w_in_drop     = readWriteIn && clearIn;
  // A wrong-branch flush only ever kills loads; stores always complete.
  assign w_kill        = r_rw && (clearIn || r_abort);

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = r_ptr[w_set];
    for (int w = WAYS-1; w >= 0; w--) begin
      if (r_valid[w_set][w] && r_tag[w][w_set] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WI'(w);
      end
      if (!r_valid[w_set][w]) w_victim = WI'(w);
    end
  end

  assign w_ptr_next     = (WAYS == 1) ? '0 : r_ptr[w_set] + 1'b1;
  assign w_victim_dirty = r_valid[w_set][w_victim] && r_dirty[w_set][w_victim];
  assign w_hit_line     = r_line[w_hit_way][w_set];
  assign w_vline        = r_line[r_victim][w_set];
  assign w_vtag         = r_tag[r_victim][w_set];

  assign w_word = 32'(w_hit_line >> {w_off, 3'b000});
  always_comb begin
    case (r_type)
      2'b01:   w_load = {24'b0, w_word[7:0]};
      2'b10:   w_load = {16'b0, w_word[15:0]};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    case (r_type)
      2'b01:   w_bmask_base = BLOCK_SIZE'(4'h1);
      2'b10:   w_bmask_base = BLOCK_SIZE'(4'h3);
      default: w_bmask_base = BLOCK_SIZE'(4'hF);
    endcase
  end
  assign w_bmask    = w_bmask_base << w_off;
  assign w_wdata_sh = LINE_W'(r_wdata) << {w_off, 3'b000};

  always_comb begin
    w_merged = w_hit_line;
    for (int i = 0; i < BLOCK_SIZE; i++)
      if (w_bmask[i]) w_merged[i*8 +: 8] = w_wdata_sh[i*8 +: 8];
  end

  always_ff @(posedge clkIn or negedge resetNIn) begin
    if (!resetNIn) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept && w_in_legal && !w_in_misalign && !w_in_drop)
          w_next = w_in_io ? S_IO : S_LOOKUP;
      S_LOOKUP:
        if (w_kill)              w_next = S_IDLE;
        else if (w_hit)          w_next = S_RESP;
        else if (w_victim_dirty) w_next = S_WB;
        else                     w_next = S_REFILL;
      S_WB:     if (memDone) w_next = S_REFILL;
      S_REFILL: if (memDone) w_next = w_kill ? S_IDLE : S_LOOKUP;
      S_RESP:   w_next = S_IDLE;
      S_IO:     if (ioDone) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    reqReady     = (r_state == S_IDLE);
    dataOutValid = 1'b0;
    dataWriteSuc = 1'b0;
    dataOut      = r_dout;
    misalignErr  = r_misalign;
    memReq       = 1'b0;
    memWrite     = 1'b0;
    memAddr      = '0;
    memWriteData = '0;
    ioReq        = 1'b0;
    ioWrite      = 1'b0;
    ioAddr       = '0;
    ioData       = '0;
    ioType       = '0;
    case (r_state)
      S_RESP: begin
        dataOutValid = r_rw && !w_kill;
        dataWriteSuc = !r_rw;
      end
      S_WB: begin
        memReq       = 1'b1;
        memWrite     = 1'b1;
        memAddr      = {w_vtag, w_set};
        memWriteData = w_vline;
      end
      S_REFILL: begin
        memReq  = 1'b1;
        memAddr = {w_tag, w_set};
      end
      S_IO: begin
        ioReq   = 1'b1;
        ioWrite = !r_rw;
        ioAddr  = r_addr;
        ioData  = r_wdata;
        ioType  = r_type;
        if (ioDone) begin
          dataOutValid = r_rw && !w_kill;
          dataWriteSuc = !r_rw;
          if (r_rw) dataOut = ioReadData;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkIn or negedge resetNIn) begin
    if (!resetNIn) begin
      r_rw       <= 1'b0;
      r_type     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_abort    <= 1'b0;
      r_misalign <= 1'b0;
      r_dout     <= '0;
      r_victim   <= '0;
    end else begin
      r_misalign <= w_accept && w_in_legal && w_in_misalign;
      if (w_accept) begin
        r_rw    <= readWriteIn;
        r_type  <= accessType;
        r_addr  <= dataAddrIn;
        r_wdata <= dataIn;
        r_abort <= 1'b0;
      end else if ((r_state == S_WB || r_state == S_REFILL || r_state == S_IO) && clearIn && r_rw) begin
        r_abort <= 1'b1;
      end
      if (r_state == S_LOOKUP && !w_kill && !w_hit) r_victim <= w_victim;
      if (r_state == S_LOOKUP && !w_kill && w_hit && r_rw) r_dout <= w_load;
    end
  end

  always_ff @(posedge clkIn or negedge resetNIn) begin
    if (!resetNIn) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else begin
      if (r_state == S_LOOKUP && !w_kill) begin
        if (w_hit && !r_rw) r_dirty[w_set][w_hit_way] <= 1'b1;
        else if (!w_hit)    r_ptr[w_set] <= w_ptr_next;
      end
      if (r_state == S_WB && memDone) r_dirty[w_set][r_victim] <= 1'b0;
      if (r_state == S_REFILL && memDone) begin
        r_valid[w_set][r_victim] <= 1'b1;
        r_dirty[w_set][r_victim] <= 1'b0;
      end
    end
  end

  // Tags and line data need no reset: valid bits gate every use.
  always_ff @(posedge clkIn) begin
    if (r_state == S_LOOKUP && w_hit && !r_rw) r_line[w_hit_way][w_set] <= w_merged;
    if (r_state == S_REFILL && memDone) begin
      r_line[r_victim][w_set] <= memReadData;
      r_tag[r_victim][w_set]  <= w_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic        r_refilled;

  always_ff @(posedge clkIn or negedge resetNIn) begin
    if (!resetNIn) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_refilled <= 1'b0;
    end else begin
      if (r_state == S_REFILL && memDone) r_refilled <= 1'b1;
      else if (w_accept)                  r_refilled <= 1'b0;
      if (r_state == S_LOOKUP && !w_kill) begin
        if (w_hit && !r_refilled) r_hit_cnt  <= r_hit_cnt + 32'd1;
        else if (!w_hit)          r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hitCount  = r_hit_cnt;
  assign missCount = r_miss_cnt;
`else
  assign hitCount  = '0;
  assign missCount = '0;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (2-way, 16-byte lines, 64 sets).
module tb_dcache_assoc;
  localparam int LW = 128;

  logic          clkIn = 1'b0;
  logic          resetNIn, clearIn, reqValid, readWriteIn;
  logic [1:0]    accessType;
  logic [31:0]   dataAddrIn, dataIn;
  logic          reqReady, dataOutValid, dataWriteSuc, misalignErr;
  logic [31:0]   dataOut;
  logic          memReq, memWrite, memDone;
  logic [27:0]   memAddr;
  logic [LW-1:0] memWriteData, memReadData;
  logic          ioReq, ioWrite, ioDone;
  logic [31:0]   ioAddr, ioData, ioReadData;
  logic [1:0]    ioType;
  logic [31:0]   hitCount, missCount;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clkIn = ~clkIn;

  dcache_assoc #(.BLOCK_WIDTH(4), .SET_WIDTH(6), .WAY_WIDTH(1)) dut (
    .clkIn(clkIn), .resetNIn(resetNIn), .clearIn(clearIn),
    .reqValid(reqValid), .reqReady(reqReady), .readWriteIn(readWriteIn),
    .accessType(accessType), .dataAddrIn(dataAddrIn), .dataIn(dataIn),
    .dataOutValid(dataOutValid), .dataOut(dataOut), .dataWriteSuc(dataWriteSuc),
    .misalignErr(misalignErr), .memReq(memReq), .memWrite(memWrite),
    .memAddr(memAddr), .memWriteData(memWriteData), .memDone(memDone),
    .memReadData(memReadData), .ioReq(ioReq), .ioWrite(ioWrite),
    .ioAddr(ioAddr), .ioData(ioData), .ioType(ioType), .ioDone(ioDone),
    .ioReadData(ioReadData), .hitCount(hitCount), .missCount(missCount)
  );

  task automatic issue(input logic rw, input logic [1:0] ty, input logic [31:0] a, input logic [31:0] d);
    int k;
    k = 0;
    while (reqReady !== 1'b1 && k < 50) begin @(negedge clkIn); k++; end
    if (reqReady !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_ready: reqReady=%b required 1 within 50 cycles", reqReady);
    end
    reqValid = 1'b1; readWriteIn = rw; accessType = ty; dataAddrIn = a; dataIn = d;
    @(negedge clkIn);
    reqValid = 1'b0;
  endtask

  task automatic wait_mem();
    int k;
    k = 0;
    while (memReq !== 1'b1 && k < 40) begin @(negedge clkIn); k++; end
    if (memReq !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_mem: memReq=%b required 1 within 40 cycles", memReq);
    end
  endtask

  task automatic mem_done(input logic [LW-1:0] d);
    memDone = 1'b1; memReadData = d;
    @(negedge clkIn);
    memDone = 1'b0; memReadData = '0;
  endtask

  task automatic wait_resp();
    int k;
    k = 0;
    while (dataOutValid !== 1'b1 && dataWriteSuc !== 1'b1 && k < 40) begin @(negedge clkIn); k++; end
    if (dataOutValid !== 1'b1 && dataWriteSuc !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_resp: no response within 40 cycles");
    end
  endtask

  task automatic test_reset();
    resetNIn = 1'b0; clearIn = 1'b0; reqValid = 1'b0; readWriteIn = 1'b0;
    accessType = 2'b00; dataAddrIn = '0; dataIn = '0; memDone = 1'b0;
    memReadData = '0; ioDone = 1'b0; ioReadData = '0;
    repeat (2) @(negedge clkIn);
    n_cmp++;
    if ({memReq, ioReq, dataOutValid, dataWriteSuc, misalignErr} !== 5'b0) begin
      n_bad++; $display("FAIL reset_pulses: got %b required 00000",
                        {memReq, ioReq, dataOutValid, dataWriteSuc, misalignErr});
    end
    n_cmp++;
    if (reqReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", reqReady); end
    n_cmp++;
    if ({dataOut, hitCount, missCount} !== 96'h0) begin
      n_bad++; $display("FAIL reset_data: dataOut=%h hit=%h miss=%h required all 0", dataOut, hitCount, missCount);
    end
    resetNIn = 1'b1;
    @(negedge clkIn);
  endtask

  task automatic test_load_miss();
    issue(1'b1, 2'b11, 32'h100, 32'h0);
    wait_mem();
    n_cmp++;
    if (memAddr !== 28'h10 || memWrite !== 1'b0) begin
      n_bad++; $display("FAIL miss_req: addr=%h write=%b required 0000010 0", memAddr, memWrite);
    end
    mem_done(128'h0F0E0D0C_0B0A0908_07060504_DDCCBBAA);
    n_cmp++;
    if (dataOutValid !== 1'b0) begin n_bad++; $display("FAIL miss_early: dataOutValid=%b required 0", dataOutValid); end
    @(negedge clkIn);
    n_cmp++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'hDDCCBBAA) begin
      n_bad++; $display("FAIL miss_resp: valid=%b data=%h required 1 ddccbbaa", dataOutValid, dataOut);
    end
  endtask

  task automatic test_store_hit();
    issue(1'b0, 2'b01, 32'h102, 32'h0000005A);
    @(negedge clkIn);
    n_cmp++;
    if (dataWriteSuc !== 1'b1 || memReq !== 1'b0) begin
      n_bad++; $display("FAIL store_hit: suc=%b memReq=%b required 1 0", dataWriteSuc, memReq);
    end
    issue(1'b1, 2'b11, 32'h100, 32'h0);
    n_cmp++;
    if (dataOutValid !== 1'b0 || memReq !== 1'b0) begin
      n_bad++; $display("FAIL hit_early: valid=%b memReq=%b required 0 0", dataOutValid, memReq);
    end
    @(negedge clkIn);
    n_cmp++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'hDD5ABBAA) begin
      n_bad++; $display("FAIL hit_word: valid=%b data=%h required 1 dd5abbaa", dataOutValid, dataOut);
    end
    issue(1'b1, 2'b10, 32'h106, 32'h0);
    @(negedge clkIn);
    n_cmp++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'h00000706) begin
      n_bad++; $display("FAIL hit_half: valid=%b data=%h required 1 00000706", dataOutValid, dataOut);
    end
    issue(1'b1, 2'b01, 32'h10F, 32'h0);
    @(negedge clkIn);
    n_cmp++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'h0000000F) begin
      n_bad++; $display("FAIL hit_byte: valid=%b data=%h required 1 0000000f", dataOutValid, dataOut);
    end
  endtask

  task automatic test_misalign();
    issue(1'b1, 2'b10, 32'h101, 32'h0);
    n_cmp++;
    if (misalignErr !== 1'b1 || reqReady !== 1'b1 || memReq !== 1'b0) begin
      n_bad++; $display("FAIL misalign_half: err=%b ready=%b memReq=%b required 1 1 0", misalignErr, reqReady, memReq);
    end
    @(negedge clkIn);
    n_cmp++;
    if (misalignErr !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse: err=%b required 0", misalignErr); end
    issue(1'b0, 2'b11, 32'h102, 32'h1);
    n_cmp++;
    if (misalignErr !== 1'b1 || memReq !== 1'b0) begin
      n_bad++; $display("FAIL misalign_word: err=%b memReq=%b required 1 0", misalignErr, memReq);
    end
    @(negedge clkIn);
  endtask

  task automatic test_evict();
    issue(1'b0, 2'b11, 32'h0000, 32'hCAFEF00D);
    wait_mem();
    mem_done(128'h00000003_00000002_00000001_00000000);
    wait_resp();
    issue(1'b0, 2'b11, 32'h0400, 32'h11112222);
    wait_mem();
    n_cmp++;
    if (memAddr !== 28'h40 || memWrite !== 1'b0) begin
      n_bad++; $display("FAIL fill_way1: addr=%h write=%b required 0000040 0", memAddr, memWrite);
    end
    mem_done(128'h10000003_10000002_10000001_10000000);
    wait_resp();
    issue(1'b1, 2'b11, 32'h0808, 32'h0);
    wait_mem();
    n_cmp++;
    if (memWrite !== 1'b1 || memAddr !== 28'h00 ||
        memWriteData !== 128'h00000003_00000002_00000001_CAFEF00D) begin
      n_bad++; $display("FAIL wb_way0: write=%b addr=%h data=%h required 1 0000000 ..._cafef00d",
                        memWrite, memAddr, memWriteData);
    end
    mem_done('0);
    n_cmp++;
    if (memReq !== 1'b1 || memWrite !== 1'b0 || memAddr !== 28'h80) begin
      n_bad++; $display("FAIL refill_after_wb: req=%b write=%b addr=%h required 1 0 0000080", memReq, memWrite, memAddr);
    end
    mem_done(128'h20000003_20000002_20000001_20000000);
    wait_resp();
    n_cmp++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'h20000002) begin
      n_bad++; $display("FAIL evict_load: valid=%b data=%h required 1 20000002", dataOutValid, dataOut);
    end
    issue(1'b1, 2'b11, 32'h0C00, 32'h0);
    wait_mem();
    n_cmp++;
    if (memWrite !== 1'b1 || memAddr !== 28'h40 ||
        memWriteData !== 128'h10000003_10000002_10000001_11112222) begin
      n_bad++; $display("FAIL wb_way1: write=%b addr=%h data=%h required 1 0000040 ..._11112222",
                        memWrite, memAddr, memWriteData);
    end
    mem_done('0);
    mem_done(128'h30000003_30000002_30000001_30000000);
    wait_resp();
    n_cmp++;
    if (dataOut !== 32'h30000000) begin n_bad++; $display("FAIL rr_load: data=%h required 30000000", dataOut); end
    issue(1'b1, 2'b11, 32'h0800, 32'h0);
    n_cmp++;
    if (memReq !== 1'b0) begin n_bad++; $display("FAIL rr_keep: memReq=%b required 0", memReq); end
    @(negedge clkIn);
    n_cmp++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'h20000000) begin
      n_bad++; $display("FAIL rr_hit: valid=%b data=%h required 1 20000000", dataOutValid, dataOut);
    end
  endtask

  task automatic test_io();
    issue(1'b1, 2'b11, 32'h30000, 32'h0);
    n_cmp++;
    if (ioReq !== 1'b1 || ioAddr !== 32'h30000 || ioWrite !== 1'b0 || ioType !== 2'b11 || memReq !== 1'b0) begin
      n_bad++; $display("FAIL io_load_req: req=%b addr=%h wr=%b type=%b memReq=%b required 1 00030000 0 11 0",
                        ioReq, ioAddr, ioWrite, ioType, memReq);
    end
    @(negedge clkIn);
    ioDone = 1'b1; ioReadData = 32'h12345678;
    #1;
    n_cmp++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'h12345678) begin
      n_bad++; $display("FAIL io_load_resp: valid=%b data=%h required 1 12345678", dataOutValid, dataOut);
    end
    @(negedge clkIn);
    ioDone = 1'b0; ioReadData = '0;
    #1;
    n_cmp++;
    if (dataOutValid !== 1'b0 || reqReady !== 1'b1 || ioReq !== 1'b0) begin
      n_bad++; $display("FAIL io_load_end: valid=%b ready=%b ioReq=%b required 0 1 0", dataOutValid, reqReady, ioReq);
    end
    issue(1'b0, 2'b10, 32'h30002, 32'h0000BEEF);
    n_cmp++;
    if (ioReq !== 1'b1 || ioWrite !== 1'b1 || ioData !== 32'h0000BEEF || ioType !== 2'b10 || ioAddr !== 32'h30002) begin
      n_bad++; $display("FAIL io_store_req: req=%b wr=%b data=%h type=%b addr=%h required 1 1 0000beef 10 00030002",
                        ioReq, ioWrite, ioData, ioType, ioAddr);
    end
    ioDone = 1'b1;
    #1;
    n_cmp++;
    if (dataWriteSuc !== 1'b1) begin n_bad++; $display("FAIL io_store_suc: suc=%b required 1", dataWriteSuc); end
    @(negedge clkIn);
    ioDone = 1'b0;
  endtask

  task automatic test_clear();
    logic seen;
    issue(1'b1, 2'b11, 32'h200, 32'h0);
    wait_mem();
    n_cmp++;
    if (memAddr !== 28'h20) begin n_bad++; $display("FAIL clear_req: addr=%h required 0000020", memAddr); end
    clearIn = 1'b1;
    @(negedge clkIn);
    clearIn = 1'b0;
    n_cmp++;
    if (memReq !== 1'b1) begin n_bad++; $display("FAIL clear_hold: memReq=%b required 1", memReq); end
    mem_done(128'h0_0_0_44332211);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dataOutValid !== 1'b0) seen = 1'b1;
      @(negedge clkIn);
    end
    n_cmp++;
    if (seen !== 1'b0 || reqReady !== 1'b1) begin
      n_bad++; $display("FAIL clear_silent: valid_seen=%b ready=%b required 0 1", seen, reqReady);
    end
    issue(1'b1, 2'b11, 32'h200, 32'h0);
    n_cmp++;
    if (memReq !== 1'b0) begin n_bad++; $display("FAIL clear_line_valid: memReq=%b required 0", memReq); end
    @(negedge clkIn);
    n_cmp++;
    if (dataOutValid !== 1'b1 || dataOut !== 32'h44332211) begin
      n_bad++; $display("FAIL clear_refetch: valid=%b data=%h required 1 44332211", dataOutValid, dataOut);
    end
  endtask

  task automatic test_reset_abandon();
    issue(1'b1, 2'b11, 32'h500, 32'h0);
    wait_mem();
    resetNIn = 1'b0;
    #1;
    n_cmp++;
    if (memReq !== 1'b0 || reqReady !== 1'b1) begin
      n_bad++; $display("FAIL reset_abandon: memReq=%b ready=%b required 0 1", memReq, reqReady);
    end
    @(negedge clkIn);
    resetNIn = 1'b1;
    @(negedge clkIn);
  endtask

  task automatic test_stats();
    logic [31:0] exp_hit, exp_miss;
    issue(1'b1, 2'b11, 32'h100, 32'h0);
    wait_mem();
    mem_done(128'h0F0E0D0C_0B0A0908_07060504_DDCCBBAA);
    wait_resp();
    issue(1'b1, 2'b11, 32'h100, 32'h0);
    wait_resp();
    issue(1'b1, 2'b11, 32'h104, 32'h0);
    wait_resp();
    n_cmp++;
    if (dataOut !== 32'h07060504) begin n_bad++; $display("FAIL stats_hit_data: data=%h required 07060504", dataOut); end
    issue(1'b1, 2'b11, 32'h400, 32'h0);
    wait_mem();
    mem_done(128'h1);
    wait_resp();
    issue(1'b1, 2'b11, 32'h400, 32'h0);
    wait_resp();
    issue(1'b1, 2'b10, 32'h101, 32'h0);
    issue(1'b1, 2'b11, 32'h30000, 32'h0);
    ioDone = 1'b1;
    @(negedge clkIn);
    ioDone = 1'b0;
    @(negedge clkIn);
`ifdef DCACHE_STATS_EN
    exp_hit = 32'd3; exp_miss = 32'd2;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    n_cmp++;
    if (hitCount !== exp_hit) begin n_bad++; $display("FAIL stats_hits: got %0d required %0d", hitCount, exp_hit); end
    n_cmp++;
    if (missCount !== exp_miss) begin n_bad++; $display("FAIL stats_misses: got %0d required %0d", missCount, exp_miss); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_misalign();
    test_evict();
    test_io();
    test_clear();
    test_reset_abandon();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
